prbs3_checker: RTL

- Receive-side counterpart of the 3-bit DRBG bit source: checks a recovered bit stream (e.g. after QPSK demapping) against the x^3+x+1 sequence.
- Self-synchronises to the sequence and reports lock, per-bit errors and a saturating error count.
- Used for loopback BER measurement of the modulator chain.
- Reference sequence from generator reset is 1,0,0,1,0,1,1 (period 7); recurrence b(n) = b(n-3) XOR b(n-2).

---
 rtl/prbs3_checker.sv | 83 ++++++++
 1 files changed

// File: rtl/prbs3_checker.sv
// prbs3_checker: self-synchronising x^3+x+1 PRBS checker with lock flywheel and saturating error count
module prbs3_checker #(
  parameter int LOCK_CNT = 8,
  parameter int UNLOCK_CNT = 4,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             err_clr,
  output logic             locked,
  output logic             bit_err,
  output logic [ERR_W-1:0] err_count
);
  typedef enum logic {SEARCH, LOCKED} state_t;
  state_t state_q, state_d;
  logic [2:0] h_q, h_d;
  logic [1:0] fill_q, fill_d;
  logic [3:0] match_q, match_d, miss_q, miss_d;
  logic bit_err_q, bit_err_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic p, inc;
  assign p = h_q[0] ^ h_q[1];
  always_comb begin
    state_d = state_q;
    h_d = h_q;
    fill_d = fill_q;
    match_d = match_q;
    miss_d = miss_q;
    bit_err_d = 1'b0;
    inc = 1'b0;
    if (din_valid) begin
      if (state_q == SEARCH) begin
        h_d = {din, h_q[2:1]};
        if (fill_q != 2'd3) fill_d = fill_q + 2'd1;
        else if (din == p && h_q != 3'b000) begin
          match_d = match_q + 4'd1;
          if (match_d == 4'(LOCK_CNT)) begin
            state_d = LOCKED;
            miss_d = '0;
          end
        end else match_d = '0;
      end else begin
        h_d = {p, h_q[2:1]};
        if (din != p) begin
          bit_err_d = 1'b1;
          inc = 1'b1;
          miss_d = miss_q + 4'd1;
          if (miss_d == 4'(UNLOCK_CNT)) begin
            state_d = SEARCH;
            fill_d = '0;
            match_d = '0;
            h_d = '0;
          end
        end else miss_d = '0;
      end
    end
    err_d = err_clr ? ERR_W'(inc) : (inc && err_q != '1) ? err_q + ERR_W'(1) : err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEARCH;
      h_q <= '0;
      fill_q <= '0;
      match_q <= '0;
      miss_q <= '0;
      bit_err_q <= 1'b0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      h_q <= h_d;
      fill_q <= fill_d;
      match_q <= match_d;
      miss_q <= miss_d;
      bit_err_q <= bit_err_d;
      err_q <= err_d;
    end
  end
  assign locked = state_q == LOCKED;
  assign bit_err = bit_err_q;
  assign err_count = err_q;
endmodule
